// File: rtl/pwm_carrier_scheduler.sv
// Shared triangular carrier timebase and output-enable sequencing for one converter leg.
// Valley-aligned period double-buffering, bootstrap precharge sequencing and fault latching.
module pwm_carrier_scheduler #(
  parameter logic [15:0] MIN_PERIOD        = 16'd100,
  parameter int          BOOTSTRAP_PERIODS = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] period_i,
  input  logic        start_i,
  input  logic        fault_i,
  input  logic        fault_clear_i,
  output logic [15:0] local_counter_o,
  output logic        sync_phase_o,
  output logic [15:0] current_period_o,
  output logic [15:0] next_period_o,
  output logic        update_o,
  output logic        enable_output_o,
  output logic [1:0]  override_o,
  output logic [1:0]  state_o,
  output logic        fault_latched_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BOOT  = 2'd1,
    RUN   = 2'd2,
    FAULT = 2'd3
  } state_e;

  // A zero-length boot sequence still needs a 1-bit counter to keep the vector legal.
  localparam int BOOT_W = (BOOTSTRAP_PERIODS > 0) ? $clog2(BOOTSTRAP_PERIODS + 1) : 1;
  localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOTSTRAP_PERIODS);

  logic [15:0]       localCounter_q, localCounter_d;
  logic              syncPhase_q, syncPhase_d;
  logic [15:0]       curPeriod_q, curPeriod_d;
  logic [15:0]       nextPeriod_q, nextPeriod_d;
  logic              update_q, update_d;
  state_e            state_q, state_d;
  logic [BOOT_W-1:0] bootCnt_q, bootCnt_d;
  logic              enable_q, enable_d;
  logic [1:0]        override_q, override_d;
  logic              faultLatched_q, faultLatched_d;

  logic              halfEnd;
  logic              valley;
  logic [15:0]       clampedPeriod;
  logic [BOOT_W-1:0] bootInc;

  always_comb begin
    halfEnd        = (localCounter_q == (curPeriod_q - 16'd1));
    valley         = halfEnd && syncPhase_q;
    clampedPeriod  = (period_i < MIN_PERIOD) ? MIN_PERIOD : period_i;
    localCounter_d = halfEnd ? 16'd0 : (localCounter_q + 16'd1);
    syncPhase_d    = halfEnd ? ~syncPhase_q : syncPhase_q;
    curPeriod_d    = valley ? nextPeriod_q : curPeriod_q;
    nextPeriod_d   = valley ? clampedPeriod : nextPeriod_q;
    update_d       = valley;
  end

  // Fault overrides everything, then acknowledge, then the valley-aligned run request.
  always_comb begin
    state_d   = state_q;
    bootCnt_d = bootCnt_q;
    bootInc   = bootCnt_q + BOOT_W'(1);
    if (fault_i) begin
      state_d = FAULT;
    end else begin
      case (state_q)
        FAULT: begin
          if (fault_clear_i) state_d = IDLE;
        end
        IDLE: begin
          if (valley && start_i) begin
            bootCnt_d = '0;
            state_d   = (BOOTSTRAP_PERIODS == 0) ? RUN : BOOT;
          end
        end
        BOOT: begin
          if (valley) begin
            if (!start_i) begin
              state_d = IDLE;
            end else begin
              bootCnt_d = bootInc;
              if (bootInc == BOOT_LAST) state_d = RUN;
            end
          end
        end
        RUN: begin
          if (valley && !start_i) state_d = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    enable_d       = (state_d == RUN);
    override_d     = (state_d == BOOT) ? 2'b10 : 2'b00;
    faultLatched_d = (state_d == FAULT);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      localCounter_q <= 16'd0;
      syncPhase_q    <= 1'b0;
      curPeriod_q    <= MIN_PERIOD;
      nextPeriod_q   <= MIN_PERIOD;
      update_q       <= 1'b0;
      state_q        <= IDLE;
      bootCnt_q      <= '0;
      enable_q       <= 1'b0;
      override_q     <= 2'b00;
      faultLatched_q <= 1'b0;
    end else begin
      localCounter_q <= localCounter_d;
      syncPhase_q    <= syncPhase_d;
      curPeriod_q    <= curPeriod_d;
      nextPeriod_q   <= nextPeriod_d;
      update_q       <= update_d;
      state_q        <= state_d;
      bootCnt_q      <= bootCnt_d;
      enable_q       <= enable_d;
      override_q     <= override_d;
      faultLatched_q <= faultLatched_d;
    end
  end

  assign local_counter_o  = localCounter_q;
  assign sync_phase_o     = syncPhase_q;
  assign current_period_o = curPeriod_q;
  assign next_period_o    = nextPeriod_q;
  assign update_o         = update_q;
  assign enable_output_o  = enable_q;
  assign override_o       = override_q;
  assign state_o          = state_q;
  assign fault_latched_o  = faultLatched_q;

endmodule
